// File: rtl/nco_pkg.sv
// Shared constants and helpers for the NCO phase generator slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nco_pkg;

  // Default accumulator and output phase widths.
  localparam int unsigned NCO_ACC_W_DEF = 32;
  localparam int unsigned NCO_PH_W_DEF  = 12;

  // Dither LFSR: x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One Galois step: shift right, fold the polynomial back in when bit 0 falls out.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ LFSR_POLY;
    end
    return r;
  endfunction

  // Number of dither bits: the truncated low bits, never more than the LFSR provides.
  function automatic int unsigned dither_w(input int unsigned acc_w, input int unsigned ph_w);
    int unsigned d;
    d = acc_w - ph_w;
    if (d > LFSR_W) begin
      d = LFSR_W;
    end
    return d;
  endfunction

endpackage

// File: rtl/nco_lfsr.sv
// 16-bit Galois LFSR producing a pseudo-random dither word, advanced by en.
// Latency: new state visible one clock after each en.
// Backpressure: none; free-running on en, state held otherwise.
module nco_lfsr
  import nco_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] lfsr_q
);

  // Advance one step per sample strobe; seed restored on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

endmodule

// File: rtl/nco_phase_gen.sv
// NCO phase generator: accumulates a shadowed tuning word per en, adds an offset, emits PH_W phase.
// Latency: en in cycle N gives phase/phase_valid in N+1; new FTW steps from the en after the applying en.
// Backpressure: ftw_ready low while the shadow holds an unapplied word; offset always accepted.
// Optional spur-whitening dither on the truncated bits is built when NCO_DITHER_EN is defined.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W = NCO_ACC_W_DEF,
  parameter int unsigned PH_W  = NCO_PH_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [ACC_W-1:0] ftw_data,
  input  logic             ftw_valid,
  output logic             ftw_ready,
  input  logic [PH_W-1:0]  pofs_data,
  input  logic             pofs_valid,
  output logic [PH_W-1:0]  phase,
  output logic             phase_valid,
  output logic             ftw_applied
);

  // Catch illegal parameterisations at elaboration time.
  if (PH_W > ACC_W || PH_W == 0) begin : g_bad_ph_w
    $error("nco_phase_gen: PH_W must be in 1..ACC_W");
  end
  if (ACC_W < 16 || ACC_W > 48) begin : g_bad_acc_w
    $error("nco_phase_gen: ACC_W must be in 16..48");
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] ftw_shadow;
  logic             shadow_full;
  logic             sync_pend;
  logic [PH_W-1:0]  pofs;

  logic             ftw_xfer;
  logic             apply_now;
  logic             zero_acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] acc_dith;
  logic [PH_W-1:0]  phase_trunc;

  // Shadow accepts a word only when empty, so capture and apply never coincide.
  assign ftw_ready = !shadow_full;
  assign ftw_xfer  = ftw_valid && !shadow_full;
  assign apply_now = en && shadow_full;

  // A sync arriving with en zeroes on that same en; otherwise it waits in sync_pend.
  assign zero_acc  = sync || sync_pend;
  assign acc_next  = zero_acc ? '0 : (acc + ftw_act);

`ifdef NCO_DITHER_EN
  localparam int unsigned DITH_W = dither_w(ACC_W, PH_W);

  logic [15:0] lfsr_q;

  nco_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .lfsr_q (lfsr_q)
  );

  // Dither only perturbs the value being truncated; the accumulator stays exact.
  if (DITH_W > 0) begin : g_dith
    logic [ACC_W-1:0] dith_ext;
    assign dith_ext = {{(ACC_W-DITH_W){1'b0}}, lfsr_q[DITH_W-1:0]};
    assign acc_dith = acc_next + dith_ext;
    if (DITH_W < 16) begin : g_lfsr_spare
      logic lfsr_spare;
      assign lfsr_spare = ^lfsr_q[15:DITH_W];
    end
  end else begin : g_nodith
    logic lfsr_spare;
    assign lfsr_spare = ^lfsr_q;
    assign acc_dith   = acc_next;
  end
`else
  assign acc_dith = acc_next;
`endif

  assign phase_trunc = acc_dith[ACC_W-1 -: PH_W];

  // Tuning-word shadow: capture on handshake, promote to active on the next en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_shadow  <= '0;
      shadow_full <= 1'b0;
      ftw_act     <= '0;
      ftw_applied <= 1'b0;
    end else begin
      ftw_applied <= apply_now;
      if (apply_now) begin
        ftw_act     <= ftw_shadow;
        shadow_full <= 1'b0;
      end else if (ftw_xfer) begin
        ftw_shadow  <= ftw_data;
        shadow_full <= 1'b1;
      end
    end
  end

  // Phase accumulator with deferred sync; the applying en still steps with the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sync_pend <= 1'b0;
    end else if (en) begin
      acc       <= acc_next;
      sync_pend <= 1'b0;
    end else if (sync) begin
      sync_pend <= 1'b1;
    end
  end

  // Phase offset register, updated whenever offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pofs <= '0;
    end else if (pofs_valid) begin
      pofs <= pofs_data;
    end
  end

  // Registered phase output: new word on each en, held with valid low otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= '0;
      phase_valid <= 1'b0;
    end else begin
      phase_valid <= en;
      if (en) begin
        phase <= phase_trunc + pofs;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen (default build, no dither).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises shadow-full ready drop and ignored offers.
module tb_nco_phase_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic [31:0] ftw_data;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [11:0] pofs_data;
  logic        pofs_valid;
  logic [11:0] phase;
  logic        phase_valid;
  logic        ftw_applied;

  int n_checks = 0;
  int n_fail   = 0;

  // Ideal accumulator reference for the stepping sequences.
  logic [31:0] m_acc;
  logic [31:0] m_ftw;
  logic [11:0] m_pofs;

  always #5 clk = ~clk;

  nco_phase_gen #(.ACC_W(32), .PH_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .ftw_data    (ftw_data),
    .ftw_valid   (ftw_valid),
    .ftw_ready   (ftw_ready),
    .pofs_data   (pofs_data),
    .pofs_valid  (pofs_valid),
    .phase       (phase),
    .phase_valid (phase_valid),
    .ftw_applied (ftw_applied)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] exp_ph();
    logic [11:0] p;
    p = m_acc[31:20] + m_pofs;
    return p;
  endfunction

  // One en-qualified step of the reference, then compare.
  task automatic en_step(input string tag);
    en = 1'b1;
    tick();
    en = 1'b0;
    m_acc = m_acc + m_ftw;
    check(tag, {20'd0, phase}, {20'd0, exp_ph()});
    check({tag, "_pv"}, {31'd0, phase_valid}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0;
    ftw_data = '0; ftw_valid = 1'b0; pofs_data = '0; pofs_valid = 1'b0;
    m_acc = '0; m_ftw = '0; m_pofs = '0;

    // Reset state
    repeat (3) tick();
    check("rst_phase", {20'd0, phase}, 32'd0);
    check("rst_pv", {31'd0, phase_valid}, 32'd0);
    check("rst_ready", {31'd0, ftw_ready}, 32'd1);
    check("rst_applied", {31'd0, ftw_applied}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_phase", {20'd0, phase}, 32'd0);
    check("post_rst_ready", {31'd0, ftw_ready}, 32'd1);

    // Shadow handshake with en low; a second offer while full must be ignored
    ftw_data = 32'h0100_0000; ftw_valid = 1'b1;
    tick();
    ftw_data = 32'h0300_0000;
    tick();
    check("hs_ready_low", {31'd0, ftw_ready}, 32'd0);
    ftw_valid = 1'b0;
    tick();
    check("hs_ready_stays_low", {31'd0, ftw_ready}, 32'd0);
    check("hs_idle_pv", {31'd0, phase_valid}, 32'd0);

    // Applying en: pulse, old (zero) step, ready back high
    en = 1'b1;
    tick();
    en = 1'b0;
    check("apply_pulse", {31'd0, ftw_applied}, 32'd1);
    check("apply_phase", {20'd0, phase}, 32'd0);
    check("apply_pv", {31'd0, phase_valid}, 32'd1);
    check("apply_ready", {31'd0, ftw_ready}, 32'd1);
    m_ftw = 32'h0100_0000;
    tick();
    check("apply_pulse_end", {31'd0, ftw_applied}, 32'd0);
    check("idle_pv", {31'd0, phase_valid}, 32'd0);

    // Full-rate stepping through one complete wrap
    en = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick();
      m_acc = m_acc + m_ftw;
      check("step", {20'd0, phase}, {20'd0, exp_ph()});
      if (i == 1)   check("step_first", {20'd0, phase}, 32'h010);
      if (i == 255) check("wrap_ff0", {20'd0, phase}, 32'hFF0);
      if (i == 256) check("wrap_000", {20'd0, phase}, 32'h000);
    end
    en = 1'b0;
    tick();
    check("hold_phase", {20'd0, phase}, 32'h000);
    check("hold_pv", {31'd0, phase_valid}, 32'd0);

    // Offset: capture without en leaves phase untouched, then shifts the sequence
    pofs_data = 12'h400; pofs_valid = 1'b1;
    tick();
    pofs_valid = 1'b0;
    m_pofs = 12'h400;
    check("ofs_hold", {20'd0, phase}, 32'h000);
    en_step("ofs_step1");
    check("ofs_410", {20'd0, phase}, 32'h410);
    en_step("ofs_step2");
    en_step("ofs_step3");
    check("ofs_430", {20'd0, phase}, 32'h430);

    // Offset wrap modulo 0x1000
    pofs_data = 12'hFF8; pofs_valid = 1'b1;
    tick();
    pofs_valid = 1'b0;
    m_pofs = 12'hFF8;
    en_step("ofs_wrap");
    check("ofs_wrap_038", {20'd0, phase}, 32'h038);

    // Offset offered with en: that step still uses the old offset
    pofs_data = 12'h400; pofs_valid = 1'b1; en = 1'b1;
    tick();
    pofs_valid = 1'b0; en = 1'b0;
    check("ofs_same_cycle", {20'd0, phase}, 32'h048);
    m_acc = m_acc + m_ftw;
    m_pofs = 12'h400;
    en_step("ofs_new");
    check("ofs_new_460", {20'd0, phase}, 32'h460);

    // Sync with en low, taken on next en
    sync = 1'b1;
    tick();
    sync = 1'b0;
    tick();
    check("sync_idle_pv", {31'd0, phase_valid}, 32'd0);
    en = 1'b1;
    tick();
    en = 1'b0;
    m_acc = '0;
    check("sync_zero", {20'd0, phase}, 32'h400);
    en_step("sync_next");
    check("sync_next_410", {20'd0, phase}, 32'h410);

    // Sync coincident with en
    sync = 1'b1; en = 1'b1;
    tick();
    sync = 1'b0; en = 1'b0;
    m_acc = '0;
    check("sync_en_zero", {20'd0, phase}, 32'h400);
    en_step("sync_en_next");

    // New FTW under full-rate en: capture, apply (old step), then new step
    ftw_data = 32'h0200_0000; ftw_valid = 1'b1; en = 1'b1;
    tick();
    ftw_valid = 1'b0;
    check("fr_cap_phase", {20'd0, phase}, 32'h420);
    check("fr_cap_ready", {31'd0, ftw_ready}, 32'd0);
    check("fr_cap_applied", {31'd0, ftw_applied}, 32'd0);
    tick();
    check("fr_apply_phase", {20'd0, phase}, 32'h430);
    check("fr_apply_pulse", {31'd0, ftw_applied}, 32'd1);
    check("fr_apply_ready", {31'd0, ftw_ready}, 32'd1);
    tick();
    check("fr_new_phase", {20'd0, phase}, 32'h450);
    check("fr_new_applied", {31'd0, ftw_applied}, 32'd0);
    tick();
    check("fr_new_phase2", {20'd0, phase}, 32'h470);
    en = 1'b0;
    tick();

    // Asynchronous reset mid-operation discards the pending shadow word
    ftw_data = 32'h0FF0_0000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    check("arst_pre_ready", {31'd0, ftw_ready}, 32'd0);
    rst_n = 1'b0;
    #2;
    check("arst_phase", {20'd0, phase}, 32'd0);
    check("arst_pv", {31'd0, phase_valid}, 32'd0);
    check("arst_ready", {31'd0, ftw_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    m_acc = '0; m_ftw = '0; m_pofs = '0;
    en_step("arst_step1");
    check("arst_no_apply", {31'd0, ftw_applied}, 32'd0);
    en_step("arst_step2");

    // Large FTW: phase walks downward through the zero boundary
    ftw_data = 32'hFFF0_0000; ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
    en_step("dn_apply");
    m_ftw = 32'hFFF0_0000;
    en_step("dn_step1");
    check("dn_fff", {20'd0, phase}, 32'hFFF);
    en_step("dn_step2");
    check("dn_ffe", {20'd0, phase}, 32'hFFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
